speedy_mc_ak_pipe: RTL and testbench

Parametrised, pipelined successor of the Speedy linear layer. It applies column mixing, then XORs in round constant plus round key (AC^AK). The tap offsets, row count and column width are all parameters. A per-transaction no-mix mode covers the final Speedy round, which skips MixColumns. The block sits between the SubBytes/ShiftColumns stage and the round register, behind valid/ready handshakes so the round datapath can stall.

---
 rtl/speedy_mc_ak_pipe.sv | 155 +++++++++++++++
 tb/tb_speedy_mc_ak_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speedy_mc_ak_pipe.sv
// speedy_mc_ak_pipe: two-stage pipelined Speedy linear layer.
//   S1 registers the column mix (or the raw state in no-mix mode) together
//   with the combined round constant/round key. S2 registers the XOR of the
//   two, which is the layer output.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready does not depend on in_valid)
//   in_state          state, row i bit j at index i*W+j
//   in_acak           round constant XOR round key
//   in_nomc           1 = bypass the mix for this transaction
//   out_valid/out_ready output handshake
//   out_state         result
//   blk_cnt, nomc_seen  only when SPEEDY_MC_CNT_EN is defined: count of
//                     completed output transfers, and a sticky flag set by
//                     any completed no-mix transfer
//
// Build option: `define SPEEDY_MC_CNT_EN to add the transfer counter ports.
module speedy_mc_ak_pipe #(
    parameter int unsigned         L     = 32,
    parameter int unsigned         W     = 6,
    parameter int unsigned         NTAPS = 7,
    parameter logic [NTAPS*8-1:0]  OFFS  = {8'd26, 8'd21, 8'd15, 8'd9, 8'd5, 8'd1, 8'd0}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [L*W-1:0]   in_state,
    input  logic [L*W-1:0]   in_acak,
    input  logic             in_nomc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [L*W-1:0]   out_state
`ifdef SPEEDY_MC_CNT_EN
    ,
    output logic [31:0]      blk_cnt,
    output logic             nomc_seen
`endif
);

    localparam int unsigned SB = L * W;

    // Column mix: each output row is the XOR of NTAPS rotated input rows.
    // Loop bounds and offsets are constant, so the modulo folds away.
    logic [SB-1:0] mix_c;
    always_comb begin
        mix_c = '0;
        for (int unsigned i = 0; i < L; i++) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                mix_c[i*W +: W] = mix_c[i*W +: W]
                    ^ in_state[((i + 32'(OFFS[k*8 +: 8])) % L) * W +: W];
            end
        end
    end

    // Pipeline registers
    logic          s1_v_q, s1_v_d;
    logic [SB-1:0] s1_mix_q, s1_mix_d;
    logic [SB-1:0] s1_key_q, s1_key_d;
    logic          s2_v_q, s2_v_d;
    logic [SB-1:0] s2_state_q, s2_state_d;

    // A stage advances when it is empty or its consumer is taking data.
    logic adv1_c, adv2_c;
    assign adv2_c = !s2_v_q || out_ready;
    assign adv1_c = !s1_v_q || adv2_c;

    assign in_ready  = !rst && adv1_c;
    assign out_valid = s2_v_q;
    assign out_state = s2_state_q;

    // Data only loads with a valid beat so out_state stays 0 until the first result.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_mix_d   = s1_mix_q;
        s1_key_d   = s1_key_q;
        s2_v_d     = s2_v_q;
        s2_state_d = s2_state_q;
        if (adv1_c) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_mix_d = in_nomc ? in_state : mix_c;
                s1_key_d = in_acak;
            end
        end
        if (adv2_c) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_state_d = s1_mix_q ^ s1_key_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_mix_q   <= '0;
            s1_key_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_state_q <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_mix_q   <= s1_mix_d;
            s1_key_q   <= s1_key_d;
            s2_v_q     <= s2_v_d;
            s2_state_q <= s2_state_d;
        end
    end

`ifdef SPEEDY_MC_CNT_EN
    // The no-mix flag rides alongside the data so it is known at output transfer.
    logic        s1_nomc_q, s1_nomc_d;
    logic        s2_nomc_q, s2_nomc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic        xfer_c;

    assign xfer_c    = s2_v_q && out_ready;
    assign blk_cnt   = cnt_q;
    assign nomc_seen = seen_q;

    always_comb begin
        s1_nomc_d = s1_nomc_q;
        s2_nomc_d = s2_nomc_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        if (adv1_c && in_valid) begin
            s1_nomc_d = in_nomc;
        end
        if (adv2_c && s1_v_q) begin
            s2_nomc_d = s1_nomc_q;
        end
        if (xfer_c) begin
            cnt_d  = cnt_q + 32'd1;
            seen_d = seen_q | s2_nomc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_nomc_q <= 1'b0;
            s2_nomc_q <= 1'b0;
            cnt_q     <= '0;
            seen_q    <= 1'b0;
        end else begin
            s1_nomc_q <= s1_nomc_d;
            s2_nomc_q <= s2_nomc_d;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
        end
    end
`endif

endmodule

// File: tb/tb_speedy_mc_ak_pipe.sv
module tb_speedy_mc_ak_pipe;

    localparam logic [191:0] K  = 192'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
    localparam logic [191:0] X  = 192'hFEDCBA9876543210A5A5A5A5C3C3C3C30F0F0F0F12345678;
    localparam logic [191:0] ONES = {192{1'b1}};
    // Impulse at row 0 col 0 lands on rows 0,6,11,17,23,27,31 (bit = row*6).
    localparam logic [191:0] IMP_EXP = (192'd1 << 0)   | (192'd1 << 36)  | (192'd1 << 66) |
                                       (192'd1 << 102) | (192'd1 << 138) | (192'd1 << 162) |
                                       (192'd1 << 186);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [191:0] in_state;
    logic [191:0] in_acak;
    logic         in_nomc;
    logic         out_valid;
    logic         out_ready;
    logic [191:0] out_state;
`ifdef SPEEDY_MC_CNT_EN
    logic [31:0]  blk_cnt;
    logic         nomc_seen;
`endif

    // Small-parameter instance for the random sweep.
    logic         p_rst;
    logic         p_in_valid;
    logic         p_in_ready;
    logic [63:0]  p_in_state;
    logic [63:0]  p_in_acak;
    logic         p_in_nomc;
    logic         p_out_valid;
    logic         p_out_ready;
    logic [63:0]  p_out_state;
`ifdef SPEEDY_MC_CNT_EN
    logic [31:0]  p_blk_cnt;
    logic         p_nomc_seen;
`endif

    always #5 clk = ~clk;

    speedy_mc_ak_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_acak   (in_acak),
        .in_nomc   (in_nomc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
`ifdef SPEEDY_MC_CNT_EN
        ,
        .blk_cnt   (blk_cnt),
        .nomc_seen (nomc_seen)
`endif
    );

    speedy_mc_ak_pipe #(
        .L     (16),
        .W     (4),
        .NTAPS (3),
        .OFFS  ({8'd2, 8'd1, 8'd0})
    ) dut_p (
        .clk       (clk),
        .rst       (p_rst),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_state  (p_in_state),
        .in_acak   (p_in_acak),
        .in_nomc   (p_in_nomc),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .out_state (p_out_state)
`ifdef SPEEDY_MC_CNT_EN
        ,
        .blk_cnt   (p_blk_cnt),
        .nomc_seen (p_nomc_seen)
`endif
    );

    typedef struct {
        logic [191:0] st;
        logic [191:0] key;
        logic         nomc;
        logic [191:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference for L=16, W=4, taps {2,1,0}.
    function automatic logic [63:0] pref(input logic [63:0] s, input logic [63:0] k, input logic nm);
        logic [63:0] m;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 4; j++) begin
                m[i*4+j] = s[((i + 2) % 16)*4 + j] ^ s[((i + 1) % 16)*4 + j] ^ s[i*4 + j];
            end
        end
        return (nm ? s : m) ^ k;
    endfunction

    vec_t         vecs[6];
    logic [191:0] seq_exp[4];
    logic [191:0] bp_key[5];
    logic [191:0] held;
    logic [63:0]  sbq[$];
    logic [63:0]  pexp;
    int           idx, nrx, ghost, sent, got;
    logic         acc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{st: 192'd1, key: '0,   nomc: 1'b0, exp: IMP_EXP};
        vecs[1] = '{st: '0,     key: K,    nomc: 1'b0, exp: K};
        vecs[2] = '{st: ONES,   key: K,    nomc: 1'b0, exp: ~K};
        vecs[3] = '{st: X,      key: K,    nomc: 1'b1, exp: X ^ K};
        vecs[4] = '{st: 192'd1, key: '0,   nomc: 1'b1, exp: 192'd1};
        vecs[5] = '{st: ONES,   key: '0,   nomc: 1'b1, exp: ONES};

        rst = 1'b1; p_rst = 1'b1;
        in_valid = 1'b0; in_state = '0; in_acak = '0; in_nomc = 1'b0; out_ready = 1'b1;
        p_in_valid = 1'b0; p_in_state = '0; p_in_acak = '0; p_in_nomc = 1'b0; p_out_ready = 1'b1;
        step;
        step;
        chk("in_ready_in_reset", 192'(in_ready), 192'd0);
        rst = 1'b0; p_rst = 1'b0;
        #1;
        chk("reset_out_valid", 192'(out_valid), 192'd0);
        chk("reset_out_state", out_state, '0);
        chk("reset_in_ready", 192'(in_ready), 192'd1);

        // Single beats, latency 2.
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1; in_state = vecs[v].st; in_acak = vecs[v].key; in_nomc = vecs[v].nomc;
            #1;
            chk($sformatf("vec%0d_in_ready", v), 192'(in_ready), 192'd1);
            step;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1_valid", v), 192'(out_valid), 192'd0);
            step;
            chk($sformatf("vec%0d_lat2_valid", v), 192'(out_valid), 192'd1);
            chk($sformatf("vec%0d_state", v), out_state, vecs[v].exp);
        end
        step;

        // Back-to-back beats with alternating mode.
        seq_exp[0] = IMP_EXP; seq_exp[1] = 192'd1; seq_exp[2] = K; seq_exp[3] = X;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin in_valid = 1'b1; in_state = 192'd1; in_acak = '0; in_nomc = 1'b0; end
                1: begin in_valid = 1'b1; in_state = 192'd1; in_acak = '0; in_nomc = 1'b1; end
                2: begin in_valid = 1'b1; in_state = '0;     in_acak = K;  in_nomc = 1'b0; end
                3: begin in_valid = 1'b1; in_state = X;      in_acak = '0; in_nomc = 1'b1; end
                default: in_valid = 1'b0;
            endcase
            step;
            if (c >= 1 && c <= 4) begin
                chk($sformatf("b2b%0d_valid", c - 1), 192'(out_valid), 192'd1);
                chk($sformatf("b2b%0d_state", c - 1), out_state, seq_exp[c - 1]);
            end
        end
        step;

        // Backpressure: out_ready low for 4 cycles while 5 beats are offered.
        for (int i = 0; i < 5; i++) bp_key[i] = {3{64'(i + 1) * 64'h9E3779B97F4A7C15}};
        idx = 0; nrx = 0; held = '0;
        for (int c = 0; c < 40 && nrx < 5; c++) begin
            out_ready = (c >= 4);
            if (idx < 5) begin
                in_valid = 1'b1; in_state = '0; in_acak = bp_key[idx]; in_nomc = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                chk("bp_in_ready_low", 192'(in_ready), 192'd0);
                chk("bp_accepted", 192'(idx), 192'd2);
                chk("bp_out_valid", 192'(out_valid), 192'd1);
                held = out_state;
            end
            if (c == 3 || c == 4) chk($sformatf("bp_hold%0d", c), out_state, held);
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", nrx), out_state, bp_key[nrx]);
                nrx++;
            end
            if (in_valid && in_ready) idx++;
            step;
        end
        in_valid = 1'b0;
        chk("bp_count", 192'(nrx), 192'd5);
        chk("bp_drained", 192'(out_valid), 192'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = '0; in_acak = K;  in_nomc = 1'b0;
        step;
        in_acak = ~K;
        step;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", 192'(in_ready), 192'd0);
        step;
        chk("rst_out_valid", 192'(out_valid), 192'd0);
        chk("rst_out_state", out_state, '0);
`ifdef SPEEDY_MC_CNT_EN
        chk("rst_blk_cnt", 192'(blk_cnt), 192'd0);
        chk("rst_nomc_seen", 192'(nomc_seen), 192'd0);
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        ghost = 0;
        for (int c = 0; c < 6; c++) begin
            step;
            if (out_valid) ghost++;
        end
        chk("rst_no_ghost", 192'(ghost), 192'd0);

        // One no-mix beat after reset.
        in_valid = 1'b1; in_state = X; in_acak = '0; in_nomc = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        chk("post_rst_state", out_state, X);
        step;
`ifdef SPEEDY_MC_CNT_EN
        chk("cnt_one", 192'(blk_cnt), 192'd1);
        chk("nomc_seen_set", 192'(nomc_seen), 192'd1);
`endif

        // Random sweep on the small instance.
        sent = 0; got = 0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            p_out_ready = ($urandom_range(0, 3) != 0);
            if (!p_in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                p_in_valid = 1'b1;
                p_in_state = {$urandom, $urandom};
                p_in_acak  = {$urandom, $urandom};
                p_in_nomc  = 1'($urandom_range(0, 1));
            end
            #1;
            acc = p_in_valid && p_in_ready;
            if (acc) begin
                sbq.push_back(pref(p_in_state, p_in_acak, p_in_nomc));
                sent++;
            end
            if (p_out_valid && p_out_ready) begin
                pexp = (sbq.size() > 0) ? sbq.pop_front() : ~p_out_state;
                chk($sformatf("sweep%0d", got), 192'(p_out_state), 192'(pexp));
                got++;
            end
            step;
            if (acc) p_in_valid = 1'b0;
        end
        chk("sweep_count", 192'(got), 192'd1000);
        chk("sweep_empty", 192'(sbq.size()), 192'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
